// File: rtl/program_loader_pkg.sv
// Shared loader types: FSM encodings, frame header byte, global bus widths.
// CSUM exists only when PROGRAM_LOADER_CHECKSUM_EN is defined.
package program_loader_pkg;

  localparam int GLB_DATA_W = 16;
  localparam int GLB_ADDR_W = 8;

  localparam logic [7:0] HDR_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEN   = 3'd1,
    ST_DATA  = 3'd2,
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    ST_CSUM  = 3'd3,
`endif
    ST_RUN   = 3'd4,
    ST_ERROR = 3'd5
  } ldr_state_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  function automatic logic is_loading(ldr_state_t s);
    logic r;
    r = (s == ST_LEN) || (s == ST_DATA);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    r = r || (s == ST_CSUM);
`endif
    return r;
  endfunction

endpackage

// File: rtl/program_loader_uart_rx_byte.sv
// 8N1 UART byte receiver; 2-flop sync, mid-bit sampling, byte_valid/frame_err pulse at mid-stop.
// No backpressure: each received byte is presented for exactly one cycle.
module uart_rx_byte
  import program_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int            CW   = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

  rx_state_t     st, st_n;
  logic          rx_meta, rx_sync, rx_prev;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;

  assign byte_data = shreg;

  always_comb begin
    st_n = st;
    case (st)
      RX_IDLE:  if (rx_prev && !rx_sync) st_n = RX_START;
      // a start bit that is high again at mid-bit was only a glitch
      RX_START: if (cnt == HALF) st_n = rx_sync ? RX_IDLE : RX_DATA;
      RX_DATA:  if (cnt == FULL && bit_idx == 3'd7) st_n = RX_STOP;
      RX_STOP:  if (cnt == FULL) st_n = RX_IDLE;
      default:  st_n = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st         <= RX_IDLE;
      rx_meta    <= 1'b1;
      rx_sync    <= 1'b1;
      rx_prev    <= 1'b1;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      st         <= st_n;
      rx_meta    <= rx;
      rx_sync    <= rx_meta;
      rx_prev    <= rx_sync;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (st)
        RX_IDLE: begin
          cnt     <= '0;
          bit_idx <= '0;
        end
        RX_START: cnt <= (cnt == HALF) ? '0 : cnt + CW'(1);
        RX_DATA: begin
          if (cnt == FULL) begin
            cnt     <= '0;
            shreg   <= {rx_sync, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RX_STOP: begin
          if (cnt == FULL) begin
            cnt        <= '0;
            byte_valid <= rx_sync;
            frame_err  <= !rx_sync;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

endmodule

// File: rtl/program_loader.sv
// UART boot loader: writes framed image to RAM from address 1, then hands the bus to the CPU.
// Write 1 cycle after last byte of a word; no backpressure. Checksum byte: PROGRAM_LOADER_CHECKSUM_EN.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int DATA_W       = GLB_DATA_W,
  parameter int ADDR_W       = GLB_ADDR_W,
  parameter int CLKS_PER_BIT = 434
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_read,
  output logic              ram_write,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              cpu_enable,
  output logic              load_busy,
  output logic              load_error
);

  localparam int             BPW       = DATA_W / 8;
  localparam int             BIW       = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [BIW-1:0] LAST_BYTE = BIW'(BPW - 1);

  logic [7:0]        byte_data;
  logic              byte_valid;
  logic              frame_err;

  ldr_state_t        state, state_n;
  logic [7:0]        word_cnt;
  logic [ADDR_W-1:0] wr_addr;
  logic [BIW-1:0]    byte_idx;
  logic [DATA_W-1:0] word_reg, word_next;
  logic              word_done;
  logic [ADDR_W-1:0] ram_addr_q;
  logic              ram_write_q;
  logic [DATA_W-1:0] ram_wdata_q;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [7:0]        csum;
`endif

  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .frame_err  (frame_err)
  );

  assign word_next = (word_reg >> 8) | (DATA_W'(byte_data) << (DATA_W - 8));
  assign word_done = byte_valid && (byte_idx == LAST_BYTE);

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:  if (byte_valid && byte_data == HDR_BYTE) state_n = ST_LEN;
      ST_LEN: begin
        if (frame_err)       state_n = ST_ERROR;
        else if (byte_valid) state_n = (byte_data == 8'd0) ? ST_ERROR : ST_DATA;
      end
      ST_DATA: begin
        if (frame_err) state_n = ST_ERROR;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        else if (word_done && word_cnt == 8'd1) state_n = ST_CSUM;
      end
      ST_CSUM: begin
        if (frame_err)       state_n = ST_ERROR;
        else if (byte_valid) state_n = (byte_data == csum) ? ST_RUN : ST_ERROR;
`else
        else if (word_done && word_cnt == 8'd1) state_n = ST_RUN;
`endif
      end
      ST_RUN:   state_n = ST_RUN;
      ST_ERROR: if (byte_valid && byte_data == HDR_BYTE) state_n = ST_LEN;
      default:  state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      word_cnt    <= '0;
      wr_addr     <= '0;
      byte_idx    <= '0;
      word_reg    <= '0;
      ram_addr_q  <= '0;
      ram_write_q <= 1'b0;
      ram_wdata_q <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      csum        <= '0;
`endif
    end else begin
      state       <= state_n;
      ram_write_q <= 1'b0;
      if (state == ST_LEN && byte_valid) begin
        word_cnt <= byte_data;
        wr_addr  <= ADDR_W'(1);
        byte_idx <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        csum     <= '0;
`endif
      end
      if (state == ST_DATA && byte_valid) begin
        word_reg <= word_next;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        csum     <= csum + byte_data;
`endif
        if (word_done) begin
          byte_idx    <= '0;
          ram_write_q <= 1'b1;
          ram_addr_q  <= wr_addr;
          ram_wdata_q <= word_next;
          wr_addr     <= wr_addr + ADDR_W'(1);
          word_cnt    <= word_cnt - 8'd1;
        end else begin
          byte_idx <= byte_idx + BIW'(1);
        end
      end
    end
  end

  // held off while the final loader write is still on the bus
  assign cpu_enable = (state == ST_RUN) && !ram_write_q;
  assign load_busy  = is_loading(state);
  assign load_error = (state == ST_ERROR);

  assign ram_addr  = cpu_enable ? cpu_addr  : ram_addr_q;
  assign ram_read  = cpu_enable ? cpu_read  : 1'b0;
  assign ram_write = cpu_enable ? cpu_write : ram_write_q;
  assign ram_wdata = cpu_enable ? cpu_wdata : ram_wdata_q;

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: frame builder predicts RAM writes and outcome, monitor checks writes.
module tb_program_loader;

  typedef struct packed {
    logic [7:0]  a;
    logic [15:0] d;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx;
  logic [7:0]  cpu_addr;
  logic        cpu_read;
  logic        cpu_write;
  logic [15:0] cpu_wdata;
  logic [7:0]  ram_addr;
  logic        ram_read;
  logic        ram_write;
  logic [15:0] ram_wdata;
  logic        cpu_enable;
  logic        load_busy;
  logic        load_error;

  int          checks   = 0;
  int          failures = 0;
  wr_t         exp_q[$];
  logic [15:0] frame_w[$];

  always #5 clk = ~clk;

  program_loader #(.DATA_W(16), .ADDR_W(8), .CLKS_PER_BIT(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .cpu_addr   (cpu_addr),
    .cpu_read   (cpu_read),
    .cpu_write  (cpu_write),
    .cpu_wdata  (cpu_wdata),
    .ram_addr   (ram_addr),
    .ram_read   (ram_read),
    .ram_write  (ram_write),
    .ram_wdata  (ram_wdata),
    .cpu_enable (cpu_enable),
    .load_busy  (load_busy),
    .load_error (load_error)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // loader-owned writes are compared against the predicted sequence
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (!rst && ram_write && !cpu_enable) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write: got addr %0h data %0h expected no write", ram_addr, ram_wdata);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", 32'(ram_addr), 32'(e.a));
          check("wr_data", 32'(ram_wdata), 32'(e.d));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b, input logic stop_ok = 1'b1);
    rx = 1'b0;
    tick(4);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(4);
    end
    rx = stop_ok;
    tick(4);
    rx = 1'b1;
    tick(stop_ok ? $urandom_range(0, 2) : 6);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rx  = 1'b1;
    #3;
    check("rst_ram_addr", 32'(ram_addr), 32'h0);
    check("rst_ram_read", 32'(ram_read), 32'h0);
    check("rst_ram_write", 32'(ram_write), 32'h0);
    check("rst_ram_wdata", 32'(ram_wdata), 32'h0);
    check("rst_cpu_enable", 32'(cpu_enable), 32'h0);
    check("rst_load_busy", 32'(load_busy), 32'h0);
    check("rst_load_error", 32'(load_error), 32'h0);
    tick(3);
    rst = 1'b0;
    exp_q.delete();
    tick(2);
  endtask

  // Header, length, little-endian words, then the mod-256 payload sum when enabled.
  task automatic send_frame(input logic bad_csum);
    logic [7:0] sum;
    sum = 8'h00;
    send_byte(8'hA5);
    send_byte(8'(frame_w.size()));
    for (int i = 0; i < frame_w.size(); i++) begin
      exp_q.push_back('{a: 8'(i + 1), d: frame_w[i]});
      send_byte(frame_w[i][7:0]);
      send_byte(frame_w[i][15:8]);
      sum = sum + frame_w[i][7:0] + frame_w[i][15:8];
    end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    send_byte(bad_csum ? sum + 8'h01 : sum);
`else
    if (bad_csum) $display("note: checksum byte not used in this build");
`endif
  endtask

  task automatic finish_frame(input string name, input logic exp_run);
    int t;
    t = 0;
    while (!(exp_run ? cpu_enable : load_error) && t < 400) begin
      tick(1);
      t++;
    end
    if (t >= 400) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: got no outcome expected %s", name, exp_run ? "run" : "error");
    end
    tick(2);
    check({name, "_enable"}, 32'(cpu_enable), 32'(exp_run));
    check({name, "_error"}, 32'(load_error), 32'(!exp_run));
    check({name, "_busy"}, 32'(load_busy), 32'h0);
    check({name, "_pending"}, 32'(exp_q.size()), 32'h0);
  endtask

  task automatic check_passthrough();
    cpu_addr  = 8'($urandom);
    cpu_read  = 1'b1;
    cpu_write = 1'b1;
    cpu_wdata = 16'($urandom);
    #1;
    check("pass_addr", 32'(ram_addr), 32'(cpu_addr));
    check("pass_read", 32'(ram_read), 32'h1);
    check("pass_write", 32'(ram_write), 32'h1);
    check("pass_wdata", 32'(ram_wdata), 32'(cpu_wdata));
    cpu_read  = 1'b0;
    cpu_write = 1'b0;
    tick(1);
  endtask

  task automatic set_words2(input logic [15:0] w0, input logic [15:0] w1);
    frame_w.delete();
    frame_w.push_back(w0);
    frame_w.push_back(w1);
  endtask

  initial begin
    int t;
    logic bad;
    logic [7:0] j;
    rst       = 1'b1;
    rx        = 1'b1;
    cpu_addr  = '0;
    cpu_read  = 1'b0;
    cpu_write = 1'b0;
    cpu_wdata = '0;
    do_reset();

    set_words2(16'h1234, 16'hABCD);
    send_frame(1'b0);
    finish_frame("basic", 1'b1);
    check_passthrough();
    do_reset();

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    set_words2(16'h1234, 16'hABCD);
    send_frame(1'b1);
    finish_frame("bad_csum", 1'b0);
    send_frame(1'b0);
    finish_frame("recover", 1'b1);
    do_reset();
`endif

    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h5A);
    frame_w.delete();
    frame_w.push_back(16'h0001);
    send_frame(1'b0);
    finish_frame("junk", 1'b1);
    do_reset();

    send_byte(8'hA5);
    send_byte(8'h00);
    finish_frame("len0", 1'b0);
    set_words2(16'h1234, 16'hABCD);
    send_frame(1'b0);
    finish_frame("len0_recover", 1'b1);
    do_reset();

    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h34);
    send_byte(8'h12, 1'b0);
    finish_frame("stop_err", 1'b0);
    do_reset();

    send_byte(8'hA5);
    send_byte(8'h02);
    exp_q.push_back('{a: 8'h01, d: 16'h1234});
    send_byte(8'h34);
    send_byte(8'h12);
    t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      tick(1);
      t++;
    end
    check("midload_first_write", 32'(exp_q.size()), 32'h0);
    check("midload_busy", 32'(load_busy), 32'h1);
    do_reset();
    set_words2(16'h1234, 16'hABCD);
    send_frame(1'b0);
    finish_frame("reload", 1'b1);
    do_reset();

    frame_w.delete();
    frame_w.push_back(16'hBEEF);
    send_frame(1'b0);
    finish_frame("beef", 1'b1);
    do_reset();

    for (int s = 0; s < 6; s++) begin
      for (int k = $urandom_range(0, 3); k > 0; k--) begin
        j = 8'($urandom);
        if (j == 8'hA5) j = 8'h00;
        send_byte(j);
      end
      frame_w.delete();
      for (int k = $urandom_range(1, 5); k > 0; k--) frame_w.push_back(16'($urandom));
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      bad = ($urandom_range(0, 3) == 0);
`else
      bad = 1'b0;
`endif
      send_frame(bad);
      finish_frame("rand", !bad);
      if (bad) begin
        send_frame(1'b0);
        finish_frame("rand_recover", 1'b1);
      end
      check_passthrough();
      do_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
